obstacle_spawner: RTL and testbench
===================================

# obstacle_spawner

Parametrised, handshaked obstacle source for the game datapath. A prescaled tick steps a 16-bit LFSR. On each eligible tick a density test and a vertical-range check decide whether an obstacle spawns. Accepted Y positions are queued in a small FIFO and consumed by the drawing/motion logic through a valid/ready port. A minimum inter-spawn gap is enforced, and FIFO overflows are counted.

## Interface
- TICK_DIV, 50000000: clk cycles per tick; legal values ≥ 1.
- MIN_GAP, 3: ticks after a spawn during which no spawn is allowed; 0..255.
- Y_W, 10: width of out_y; legal range 1..16.
- Y_MIN, 0: lowest legal Y.
- Y_MAX, 479: highest legal Y; must satisfy Y_MIN ≤ Y_MAX < 2^Y_W.
- FIFO_DEPTH, 4: number of queued spawns; power of two, ≥ 2.
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high.
- enable  in  1  gates the tick counter, LFSR and cooldown; FIFO output is unaffected.
- density  in  9  spawn threshold; 0 = never spawn, 256 = always pass.
- seed_load  in  1  synchronous one-cycle strobe that loads seed.
- seed  in  16  LFSR seed value.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_y  out  Y_W  head entry; 0 when out_valid=0.
- drop_cnt  out  8  saturating count of spawns lost to a full FIFO.

## Operation
- Tick counter tcnt:
  - Counts 0..TICK_DIV-1 while enable=1; holds while enable=0.
  - tick=1 for the one cycle where tcnt==TICK_DIV-1 and enable=1; tcnt wraps to 0 on that edge.
  - TICK_DIV=1 gives a tick every enabled cycle.
- LFSR lfsr[15:0]:
  - Fibonacci form, shifts left.
  - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; next = {lfsr[14:0], fb}.
  - Advances on every tick.
- Cooldown gap_cnt (8 bits):
  - Two states: COOL (gap_cnt>0) and ARMED (gap_cnt==0).
  - In COOL, each tick decrements gap_cnt.
  - In ARMED, a tick evaluates a candidate.
- Candidate evaluation uses the pre-step lfsr value:
  - pass_d = ({1'b0, lfsr[15:8]} < density).
  - raw = lfsr[Y_W-1:0] zero-extended; pass_r = (raw ≤ Y_MAX-Y_MIN).
  - spawn = pass_d & pass_r.
  - y = Y_MIN + raw, computed with width Y_W+1 and truncated to Y_W. No overflow is possible given the parameter constraints.
- On spawn: gap_cnt ← MIN_GAP, and y is pushed to the FIFO. A rejected candidate leaves the state ARMED.
- MIN_GAP=0: every tick is eligible.
- FIFO behaviour:
  - Pop on out_valid & out_ready.
  - Push when full and not popping in the same cycle: the entry is dropped and drop_cnt increments, saturating at 255. gap_cnt still reloads.
  - Push and pop in the same cycle while full: both happen, no drop, occupancy unchanged.
  - Push and pop in the same cycle while empty: push only (out_valid is 0, so no pop).
- seed_load:
  - lfsr ← seed, or 16'hACE1 if seed==0; tcnt ← 0; gap_cnt ← MIN_GAP.
  - FIFO and drop_cnt are untouched.
  - seed_load overrides any tick in the same cycle (no step, no spawn).
  - seed_load acts regardless of enable.
- lfsr never reaches 0; no other lockup guard is required.

## Timing
- Reset values: tcnt=0, lfsr=16'hACE1, gap_cnt=MIN_GAP, FIFO empty, out_valid=0, out_y=0, drop_cnt=0.
- Reset asserted mid-operation clears everything immediately (asynchronous), including queued entries.
- First tick after reset release with enable=1 occurs on the TICK_DIV-th rising edge.
- Spawn latency: an entry pushed on the tick edge gives out_valid=1 and out_y valid after that same edge, i.e. visible in the cycle following the tick cycle.
- out_y is combinational from the FIFO head (registered storage). A pop on edge k exposes the next entry after edge k.
- Decisions are all registered: one tick produces at most one spawn.
- A density or enable change takes effect on the next tick evaluation.

## Test plan
- Baseline sequence. Y_MIN=0, Y_MAX=1023, MIN_GAP=0, TICK_DIV=4, density=256, out_ready=1 -> ticks on edges 4 and 8 push y=225 (0x0E1) then y=451 (0x1C3); lfsr reads 0x59C3 after the first tick and 0xB387 after the second.
- Range rejection. As baseline but Y_MAX=479 -> first two spawns are 225 and 451. The third candidate (raw 903) is rejected with no push. gap_cnt stays 0.
- Cooldown. MIN_GAP=2, density=256 -> after reset, ticks 1–2 only count down and tick 3 spawns. Subsequent spawns occur on every 3rd tick.
- Overflow. FIFO_DEPTH=4, out_ready=0, MIN_GAP=0, Y_MAX=1023, density=256 -> 4 entries queued, then drop_cnt increments once per further tick. Raising out_ready on a tick cycle while full: no drop, occupancy stays 4.
- Density and seed. density=0 -> no push for 100 ticks. seed_load with seed=0 -> lfsr=0xACE1. seed_load coincident with a tick -> no step, no spawn, tcnt=0.
- Async reset mid-stream with 3 entries queued -> out_valid=0, drop_cnt=0, lfsr=0xACE1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Tick-driven LFSR obstacle source: density/range test, minimum spawn gap,
// and a small FIFO of spawn Y positions drained through a valid/ready port.
module obstacle_spawner #(
    parameter int TICK_DIV   = 50000000,
    parameter int MIN_GAP    = 3,
    parameter int Y_W        = 10,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [8:0]     density,
    input  logic           seed_load,
    input  logic [15:0]    seed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] out_y,
    output logic [7:0]     drop_cnt
);

    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [15:0]       LFSR_INIT = 16'hACE1;
    localparam logic [7:0]        GAP_INIT  = 8'(MIN_GAP);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [Y_W:0]      Y_SPAN    = (Y_W + 1)'(Y_MAX - Y_MIN);
    localparam logic [Y_W:0]      Y_BASE    = (Y_W + 1)'(Y_MIN);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {COOL, ARMED} state_t;

    logic [TCNT_W-1:0] r_tcnt,  w_tcnt_nxt;
    logic [15:0]       r_lfsr,  w_lfsr_nxt;
    logic [7:0]        r_gap_cnt, w_gap_nxt;
    logic [Y_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic [7:0]        r_drop_cnt;

    state_t         w_state;
    logic           w_tick, w_fb, w_pass_d, w_pass_r, w_spawn;
    logic           w_full, w_pop, w_push, w_drop;
    logic [Y_W:0]   w_raw;
    logic [Y_W-1:0] w_y;
    logic [15:0]    w_seed_val;

    assign w_state    = (r_gap_cnt == 8'd0) ? ARMED : COOL;
    assign w_tick     = enable & (r_tcnt == TCNT_LAST) & ~seed_load;
    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_seed_val = (seed == 16'd0) ? LFSR_INIT : seed;

    // Candidate is judged on the lfsr value before this tick's step.
    assign w_raw    = {1'b0, r_lfsr[Y_W-1:0]};
    assign w_pass_d = ({1'b0, r_lfsr[15:8]} < density);
    assign w_pass_r = (w_raw <= Y_SPAN);
    assign w_y      = Y_W'(Y_BASE + w_raw);
    assign w_spawn  = w_tick & (w_state == ARMED) & w_pass_d & w_pass_r;

    assign w_full = (r_count == FIFO_FULL);
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_spawn & (~w_full | w_pop);
    assign w_drop = w_spawn & w_full & ~w_pop;

    assign out_valid = (r_count != '0);
    assign out_y     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign drop_cnt  = r_drop_cnt;

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        w_lfsr_nxt = r_lfsr;
        w_gap_nxt  = r_gap_cnt;
        if (seed_load) begin
            w_tcnt_nxt = '0;
            w_lfsr_nxt = w_seed_val;
            w_gap_nxt  = GAP_INIT;
        end else if (enable) begin
            w_tcnt_nxt = w_tick ? '0 : r_tcnt + TCNT_W'(1);
            if (w_tick) begin
                w_lfsr_nxt = {r_lfsr[14:0], w_fb};
                case (w_state)
                    COOL:    w_gap_nxt = r_gap_cnt - 8'd1;
                    ARMED:   if (w_spawn) w_gap_nxt = GAP_INIT;
                    default: w_gap_nxt = r_gap_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt    <= '0;
            r_lfsr    <= LFSR_INIT;
            r_gap_cnt <= GAP_INIT;
        end else begin
            r_tcnt    <= w_tcnt_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    // FIFO control; storage below is qualified by r_count so it needs no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_y;
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: two configurations share stimulus and are
// checked every cycle against a behavioural model whose FIFO is the scoreboard queue.
module tb_obstacle_spawner;

    localparam int TD_A = 4, MG_A = 0, YMIN_A = 0,  YMAX_A = 479,  D_A = 4;
    localparam int TD_B = 1, MG_B = 2, YMIN_B = 10, YMAX_B = 1000, D_B = 2;

    logic        clk = 1'b0;
    logic        reset, enable, seed_load, out_ready;
    logic [8:0]  density;
    logic [15:0] seed;
    logic        a_valid, b_valid;
    logic [9:0]  a_y, b_y;
    logic [7:0]  a_drop, b_drop;

    int checks = 0;
    int failures = 0;

    obstacle_spawner #(.TICK_DIV(TD_A), .MIN_GAP(MG_A), .Y_W(10), .Y_MIN(YMIN_A),
                       .Y_MAX(YMAX_A), .FIFO_DEPTH(D_A)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .density(density),
        .seed_load(seed_load), .seed(seed), .out_valid(a_valid),
        .out_ready(out_ready), .out_y(a_y), .drop_cnt(a_drop));

    obstacle_spawner #(.TICK_DIV(TD_B), .MIN_GAP(MG_B), .Y_W(10), .Y_MIN(YMIN_B),
                       .Y_MAX(YMAX_B), .FIFO_DEPTH(D_B)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .density(density),
        .seed_load(seed_load), .seed(seed), .out_valid(b_valid),
        .out_ready(out_ready), .out_y(b_y), .drop_cnt(b_drop));

    always #5 clk = ~clk;

    // Behavioural model state; q_a/q_b hold expected FIFO contents.
    int          P_TD[2]   = '{TD_A, TD_B};
    int          P_MG[2]   = '{MG_A, MG_B};
    int          P_YMIN[2] = '{YMIN_A, YMIN_B};
    int          P_YMAX[2] = '{YMAX_A, YMAX_B};
    int          P_D[2]    = '{D_A, D_B};
    int          m_tcnt[2];
    int          m_gap[2];
    int          m_drop[2];
    logic [15:0] m_lfsr[2];
    int          q_a[$];
    int          q_b[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tcnt[k] = 0;
            m_gap[k]  = P_MG[k];
            m_drop[k] = 0;
            m_lfsr[k] = 16'hACE1;
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int sz;
            int raw;
            int y;
            bit pop, full, tick, spawn;
            sz    = (k == 0) ? q_a.size() : q_b.size();
            pop   = (sz > 0) && out_ready;
            full  = (sz == P_D[k]);
            tick  = enable && (m_tcnt[k] == P_TD[k] - 1) && !seed_load;
            spawn = 1'b0;
            y     = 0;
            if (seed_load) begin
                m_lfsr[k] = (seed == 16'd0) ? 16'hACE1 : seed;
                m_tcnt[k] = 0;
                m_gap[k]  = P_MG[k];
            end else if (enable) begin
                if (tick) begin
                    raw = int'(m_lfsr[k][9:0]);
                    if (m_gap[k] > 0) m_gap[k]--;
                    else if ((int'(m_lfsr[k][15:8]) < int'(density)) &&
                             (raw <= P_YMAX[k] - P_YMIN[k])) begin
                        spawn    = 1'b1;
                        y        = P_YMIN[k] + raw;
                        m_gap[k] = P_MG[k];
                    end
                    m_lfsr[k] = lfsr_next(m_lfsr[k]);
                    m_tcnt[k] = 0;
                end else begin
                    m_tcnt[k]++;
                end
            end
            if (pop) begin
                if (k == 0) void'(q_a.pop_front());
                else        void'(q_b.pop_front());
            end
            if (spawn) begin
                if (!full || pop) begin
                    if (k == 0) q_a.push_back(y);
                    else        q_b.push_back(y);
                end else if (m_drop[k] < 255) begin
                    m_drop[k]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("a_valid", a_valid, (q_a.size() > 0));
        chk("a_y",     a_y,     (q_a.size() > 0) ? q_a[0] : 0);
        chk("a_drop",  a_drop,  m_drop[0]);
        chk("b_valid", b_valid, (q_b.size() > 0));
        chk("b_y",     b_y,     (q_b.size() > 0) ? q_b[0] : 0);
        chk("b_drop",  b_drop,  m_drop[1]);
    endtask

    // One clock: model advances on the current inputs, DUT checked #1 after the edge.
    task automatic cyc();
        if (reset) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        density   = 9'd256;
        seed_load = 1'b0;
        seed      = 16'd0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) cyc();
        chk("rst_lfsr_a", dut_a.r_lfsr, 16'hACE1);
        chk("rst_gap_b",  dut_b.r_gap_cnt, MG_B);

        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (i == 3) begin
                chk("cool_b_valid", b_valid, 1);
                chk("cool_b_y", b_y, 913);
            end
            if (i == 4) begin
                chk("base_y0", a_y, 225);
                chk("base_lfsr0", dut_a.r_lfsr, 16'h59C3);
            end
            if (i == 8) begin
                chk("base_y1", a_y, 451);
                chk("base_lfsr1", dut_a.r_lfsr, 16'hB387);
            end
            if (i == 12) begin
                chk("range_reject", a_valid, 0);
                chk("range_gap", dut_a.r_gap_cnt, 0);
            end
        end

        out_ready = 1'b0;
        repeat (48) cyc();
        chk("ovf_occ", dut_a.r_count, 4);
        chk("ovf_drop_nz", (a_drop != 8'd0), 1);
        for (int i = 0; i < 8 && m_tcnt[0] != TD_A - 1; i++) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("full_pop_occ", dut_a.r_count, q_a.size());

        density   = 9'd0;
        out_ready = 1'b1;
        repeat (400) cyc();
        chk("dens0_a", a_valid, 0);
        chk("dens0_b", b_valid, 0);

        seed_load = 1'b1;
        seed      = 16'd0;
        cyc();
        seed_load = 1'b0;
        chk("seed0_a", dut_a.r_lfsr, 16'hACE1);
        chk("seed0_b", dut_b.r_lfsr, 16'hACE1);

        density = 9'd256;
        for (int i = 0; i < 8 && m_tcnt[0] != TD_A - 1; i++) cyc();
        seed_load = 1'b1;
        seed      = 16'h1234;
        cyc();
        seed_load = 1'b0;
        chk("seed_tick_lfsr", dut_a.r_lfsr, 16'h1234);
        chk("seed_tick_tcnt", dut_a.r_tcnt, 0);
        chk("seed_tick_nopush", a_valid, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 200 && q_a.size() != 3; i++) cyc();
        chk("q3_reached", q_a.size(), 3);
        chk("q3_occ", dut_a.r_count, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", a_valid, 0);
        chk("areset_drop", a_drop, 0);
        chk("areset_lfsr", dut_a.r_lfsr, 16'hACE1);
        chk("areset_b_valid", b_valid, 0);
        model_reset();
        repeat (2) cyc();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (24) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
